// File: rtl/eb_pkg.sv
// Shared types for the elastic-buffer stages.
// The state encoding equals buffer occupancy, so the state flop doubles as the count.
package eb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } eb2_state_t;

endpackage

// File: rtl/eb2_ctrl.sv
// Control path of the two-entry elastic buffer.
// Produces flopped handshake outputs and the data-register enables.
module eb2_ctrl
    import eb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       t_0_valid,
    input  logic       i_0_ready,
    output logic       t_0_ready,
    output logic       i_0_valid,
    output logic       en_main,
    output logic       en_skid,
    output logic       sel_skid,
    output logic [1:0] count
);

    eb2_state_t state_q;
    eb2_state_t state_d;
    logic       push;
    logic       pop;

    assign push  = t_0_valid & t_0_ready;
    assign pop   = i_0_valid & i_0_ready;
    assign count = state_q;

    // Handshake outputs are decoded from the next state so they leave straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            t_0_ready <= 1'b1;
            i_0_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_0_ready <= (state_d != FULL);
            i_0_valid <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = HALF;
            HALF: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = HALF;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        en_main  = 1'b0;
        en_skid  = 1'b0;
        sel_skid = 1'b0;
        case (state_q)
            EMPTY: en_main = push;
            HALF: begin
                en_main = push & pop;
                en_skid = push & ~pop;
            end
            FULL: begin
                en_main  = pop;
                sel_skid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eb2_ctrl_buf.sv
// Two-entry elastic buffer: registers both the valid and the ready path
// while sustaining one transfer per cycle.
module eb2_ctrl_buf
    import eb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_0_valid,
    output logic             t_0_ready,
    input  logic [WIDTH-1:0] t_0_data,
    output logic             i_0_valid,
    input  logic             i_0_ready,
    output logic [WIDTH-1:0] i_0_data,
    output logic [1:0]       count
);

    logic             en_main;
    logic             en_skid;
    logic             sel_skid;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;

    eb2_ctrl u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_0_valid (t_0_valid),
        .i_0_ready (i_0_ready),
        .t_0_ready (t_0_ready),
        .i_0_valid (i_0_valid),
        .en_main   (en_main),
        .en_skid   (en_skid),
        .sel_skid  (sel_skid),
        .count     (count)
    );

    // The head entry refills from the skid entry when draining out of FULL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (en_main) main_reg <= sel_skid ? skid_reg : t_0_data;
            if (en_skid) skid_reg <= t_0_data;
        end
    end

    assign i_0_data = main_reg;

endmodule

// File: tb/tb_eb2_ctrl_buf.sv
// Self-checking bench for eb2_ctrl_buf: directed vector table, reset and
// scoreboard-based random stress.
module tb_eb2_ctrl_buf;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             t_0_valid;
    logic             t_0_ready;
    logic [WIDTH-1:0] t_0_data;
    logic             i_0_valid;
    logic             i_0_ready;
    logic [WIDTH-1:0] i_0_data;
    logic [1:0]       count;

    int tests = 0;
    int fails = 0;

    eb2_ctrl_buf #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_0_valid (t_0_valid),
        .t_0_ready (t_0_ready),
        .t_0_data  (t_0_data),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
        .i_0_data  (i_0_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        ready;
        logic [31:0] data;
        logic [1:0]  exp_count;
        logic        exp_t_ready;
        logic        exp_i_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [1:0] c, input logic tr,
                                 input logic iv, input logic [31:0] d);
        check({name, ".count"}, 64'(count), 64'(c));
        check({name, ".t_0_ready"}, 64'(t_0_ready), 64'(tr));
        check({name, ".i_0_valid"}, 64'(i_0_valid), 64'(iv));
        check({name, ".i_0_data"}, 64'(i_0_data), 64'(d));
    endtask

    function automatic vec_t mk(logic v, logic r, logic [31:0] d, logic [1:0] c,
                                logic tr, logic iv, logic [31:0] ed);
        vec_t x;
        x.valid = v; x.ready = r; x.data = d; x.exp_count = c;
        x.exp_t_ready = tr; x.exp_i_valid = iv; x.exp_data = ed;
        return x;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        t_0_valid = 1'b0;
        i_0_ready = 1'b0;
        t_0_data  = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    int unsigned    next_val;
    logic [31:0]    sb[$];
    logic           prev_stall;
    logic [31:0]    prev_data;

    initial begin
        // Streaming 0x01..0x10 with downstream always ready
        for (int i = 1; i <= 16; i++) vecs.push_back(mk(1, 1, 32'(i), 1, 1, 1, 32'(i)));
        vecs.push_back(mk(0, 1, 32'hFF, 0, 1, 0, 32'h10));
        // Fill and stall
        vecs.push_back(mk(1, 0, 32'h0A, 1, 1, 1, 32'h0A));
        vecs.push_back(mk(1, 0, 32'h0B, 2, 0, 1, 32'h0A));
        vecs.push_back(mk(1, 0, 32'h0C, 2, 0, 1, 32'h0A));
        vecs.push_back(mk(1, 0, 32'h0C, 2, 0, 1, 32'h0A));
        // Drain from FULL: 0x0A, 0x0B, then 0x0C accepted after ready returns
        vecs.push_back(mk(1, 1, 32'h0C, 1, 1, 1, 32'h0B));
        vecs.push_back(mk(1, 1, 32'h0C, 1, 1, 1, 32'h0C));
        vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h0C));
        // Single-entry toggle
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, 0, 32'h50 + 32'(i), 1, 1, 1, 32'h50 + 32'(i)));
            vecs.push_back(mk(0, 1, 32'h00, 0, 1, 0, 32'h50 + 32'(i)));
        end

        do_reset();
        #1 check_outputs("reset", 2'd0, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            t_0_valid = vecs[i].valid;
            i_0_ready = vecs[i].ready;
            t_0_data  = vecs[i].data;
            @(posedge clk);
            #1 check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_t_ready,
                             vecs[i].exp_i_valid, vecs[i].exp_data);
        end

        // Asynchronous reset while FULL
        t_0_valid = 1'b1; i_0_ready = 1'b0; t_0_data = 32'hA1;
        @(posedge clk); #1 t_0_data = 32'hA2;
        @(posedge clk); #1 t_0_valid = 1'b0;
        check("prereset.count", 64'(count), 64'd2);
        #2 reset_n = 1'b0;
        #1 check_outputs("async_reset", 2'd0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Random stress with scoreboard
        next_val   = 1;
        prev_stall = 1'b0;
        prev_data  = '0;
        t_0_data   = 32'(next_val);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            t_0_valid = 1'($urandom_range(0, 1));
            i_0_ready = 1'($urandom_range(0, 1));
            t_0_data  = 32'(next_val);
            @(negedge clk);
            if (count > 2'd2 || count != 2'(sb.size())) begin
                check("rnd.count", 64'(count), 64'(sb.size()));
            end else tests++;
            if (prev_stall) begin
                check("rnd.stable_valid", 64'(i_0_valid), 64'd1);
                check("rnd.stable_data", 64'(i_0_data), 64'(prev_data));
            end
            if (i_0_valid && i_0_ready) begin
                if (sb.size() == 0) check("rnd.pop_empty", 64'(i_0_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("rnd.order", 64'(i_0_data), 64'(sb.pop_front()));
            end
            if (t_0_valid && t_0_ready) begin
                sb.push_back(32'(next_val));
                next_val++;
            end
            prev_stall = i_0_valid & ~i_0_ready;
            prev_data  = i_0_data;
            @(posedge clk); #1;
        end

        // Drain remaining entries; bounded so a stuck DUT still terminates
        t_0_valid = 1'b0;
        i_0_ready = 1'b1;
        for (int cyc = 0; cyc < 8 && sb.size() != 0; cyc++) begin
            @(negedge clk);
            if (i_0_valid) check("drain.order", 64'(i_0_data), 64'(sb.pop_front()));
            @(posedge clk); #1;
        end
        check("drain.left", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("drain.count", 64'(count), 64'd0);
        check("drain.i_0_valid", 64'(i_0_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
